button_conditioner: RTL and testbench
=====================================

# button_conditioner

Front-end input stage for the two paddle buttons: converts raw, bouncing, asynchronous push-button levels into clean, synchronous signals for the game logic. Per button it provides a 2-flop synchronizer, a counter-based debouncer, a one-cycle press pulse, a release pulse, and an optional auto-repeat pulse train. It sits directly upstream of the top-level `BTN_LEFT`/`BTN_RIGHT` inputs in the 40 MHz domain.

## Interface
- `DEBOUNCE_CYCLES`, 400000: consecutive cycles a new synchronized level must persist before it is accepted (10 ms at 40 MHz); legal 2..2^24-1.
- `REPEAT_DELAY_CYCLES`, 16000000: cycles from the initial press pulse to the first repeat pulse (400 ms); legal 1..2^24-1.
- `REPEAT_PERIOD_CYCLES`, 4000000: cycles between subsequent repeat pulses (100 ms); legal 1..2^24-1.
- `REPEAT_ENABLE`, 1: 0 suppresses all repeat pulses.
- `RAW_ACTIVE_LOW`, 0: 1 inverts both raw inputs before synchronization.
- `CLK` input 1: 40 MHz system clock; all logic on the rising edge.
- `RESET_N` input 1: asynchronous, active-low reset.
- `BTN_LEFT_RAW` input 1: raw left button, asynchronous.
- `BTN_RIGHT_RAW` input 1: raw right button, asynchronous.
- `BTN_LEFT` output 1: debounced left level, active-high.
- `BTN_RIGHT` output 1: debounced right level, active-high.
- `LEFT_PRESS` output 1: one-cycle pulse on the accepted press and on each repeat.
- `RIGHT_PRESS` output 1: same, for the right button.
- `LEFT_RELEASE` output 1: one-cycle pulse on the accepted release.
- `RIGHT_RELEASE` output 1: same, for the right button.

## Operation
- The two channels are identical and fully independent. Every statement below applies per channel.
- **Synchronizer:** `s1 <= raw ^ RAW_ACTIVE_LOW`, then `s2 <= s1`. Both flops reset to 0.
- **Debouncer:** 24-bit counter `cnt` and register `stable`, which drives `BTN_*`.
  - `s2 == stable`: `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2` and `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - A mismatch lasting fewer than `DEBOUNCE_CYCLES` consecutive cycles never changes `stable`.
- **Edge detection:**
  - `rise` = `stable` about to go 0→1.
  - `fall` = `stable` about to go 1→0.
  - `*_RELEASE` is registered from `fall` and is high for exactly one cycle.
- **Repeat FSM:** states IDLE, DELAY, REPEAT. Uses a 24-bit counter `rcnt`.
  - IDLE: on `rise`, pulse PRESS, `rcnt <= 0`, go to DELAY.
  - DELAY: `rcnt` increments. When `rcnt == REPEAT_DELAY_CYCLES-1`, pulse PRESS (only if `REPEAT_ENABLE`), `rcnt <= 0`, go to REPEAT.
  - REPEAT: when `rcnt == REPEAT_PERIOD_CYCLES-1`, pulse PRESS (only if `REPEAT_ENABLE`), `rcnt <= 0`.
  - Any state: `fall` forces IDLE and `rcnt <= 0`. A `fall` coinciding with a repeat expiry suppresses that repeat pulse; `fall` has priority.
  - With `REPEAT_ENABLE=0`, the FSM still walks its states, but only the initial press pulse appears.
- **Reset:** all outputs 0, all counters 0, `stable` 0, FSM in IDLE. A button already held when `RESET_N` deasserts is treated as a new press and produces PRESS after the normal latency.
- Reset asserted mid-count or mid-repeat returns to the reset state immediately. No pulse is emitted on reset entry or exit.

## Timing
- The raw level is captured by `s1` at edge k. `s2` reflects it at edge k+1.
- After a clean transition held steady, `stable`/`BTN_*` changes at edge k+1+`DEBOUNCE_CYCLES`.
- `*_PRESS` / `*_RELEASE` are high during the cycle after that edge. Pulses are registered, never combinational.
- Raw→pulse latency is `DEBOUNCE_CYCLES+2` cycles.
- Repeat pulses:
  - First repeat: `REPEAT_DELAY_CYCLES` cycles after the initial PRESS pulse.
  - Subsequent repeats: every `REPEAT_PERIOD_CYCLES` cycles.
- Left and right pulses may occur in the same cycle. There is no arbitration between channels.
- All outputs are registered.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY_CYCLES=10`, `REPEAT_PERIOD_CYCLES=5`, `REPEAT_ENABLE=1`.
- **Clean press/release:** left raw 0→1 at edge k, held 30 cycles, then 0.
  - `BTN_LEFT` rises at edge k+5.
  - `LEFT_PRESS` is high for 1 cycle after k+5.
  - Repeats occur at +10, +15, +20 cycles.
  - On release: `LEFT_RELEASE` is a single pulse 6 cycles after the raw fall. No further PRESS pulses.
- **Bounce rejection:** raw toggles every 3 cycles for 24 cycles, then stays 1.
  - No pulses and `BTN_LEFT=0` during the toggling.
  - A single PRESS follows 6 cycles after the final rise.
- **Release coinciding with a repeat expiry:** raw falls so that `fall` lands on the cycle `rcnt` hits 4 in REPEAT.
  - No PRESS pulse in that cycle.
  - `LEFT_RELEASE` pulses once and the FSM is in IDLE.
- **Simultaneous buttons:** both raws rise on the same edge.
  - `LEFT_PRESS` and `RIGHT_PRESS` pulse in the same cycle, and both repeat trains stay aligned.
- **Held across reset:** raw=1 while `RESET_N`=0 for 8 cycles, then reset released.
  - All outputs stay 0 during reset.
  - PRESS pulses 6 cycles after reset release.
  - Then assert `RESET_N`=0 mid-DELAY: outputs clear immediately and no pulse is emitted.
- **`RAW_ACTIVE_LOW=1`, `REPEAT_ENABLE=0`:** raw 1→0, held 40 cycles.
  - One PRESS pulse, `BTN_LEFT=1`, no repeats.
  - Raw back to 1: one RELEASE pulse.

Source files
------------

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - two-channel push-button synchronizer, debouncer and press/release/repeat pulse generator

module button_conditioner_chan #(
  parameter int DEBOUNCE_CYCLES      = 400000,
  parameter int REPEAT_DELAY_CYCLES  = 16000000,
  parameter int REPEAT_PERIOD_CYCLES = 4000000,
  parameter int REPEAT_ENABLE        = 1,
  parameter int RAW_ACTIVE_LOW       = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam logic        RAW_INV  = (RAW_ACTIVE_LOW != 0);
  localparam logic        REP_EN   = (REPEAT_ENABLE != 0);
  localparam logic [23:0] DB_LAST  = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] RD_LAST  = 24'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [23:0] RP_LAST  = 24'(REPEAT_PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic        s1;
  logic        s2;
  logic        stable;
  logic [23:0] cnt;
  logic        accept;
  logic        rise;
  logic        fall;

  state_t      state;
  state_t      state_nxt;
  logic [23:0] rcnt;
  logic [23:0] rcnt_nxt;
  logic        press_nxt;
  logic        rel_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw ^ RAW_INV;
      s2 <= s1;
    end
  end

  // accept fires on the last cycle of an unbroken mismatch run
  assign accept = (s2 != stable) && (cnt == DB_LAST);
  assign rise   = accept & s2;
  assign fall   = accept & ~s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      cnt    <= 24'd0;
    end else if (s2 == stable) begin
      cnt <= 24'd0;
    end else if (cnt == DB_LAST) begin
      stable <= s2;
      cnt    <= 24'd0;
    end else begin
      cnt <= cnt + 24'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rcnt  <= 24'd0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
      press <= press_nxt;
      rel   <= rel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    if (fall) begin
      state_nxt = IDLE;
      rcnt_nxt  = 24'd0;
    end else begin
      case (state)
        IDLE: begin
          rcnt_nxt = 24'd0;
          if (rise) state_nxt = DELAY;
        end
        DELAY: begin
          if (rcnt == RD_LAST) begin
            state_nxt = REPEAT;
            rcnt_nxt  = 24'd0;
          end else begin
            rcnt_nxt = rcnt + 24'd1;
          end
        end
        REPEAT: begin
          if (rcnt == RP_LAST) rcnt_nxt = 24'd0;
          else                 rcnt_nxt = rcnt + 24'd1;
        end
        default: begin
          state_nxt = IDLE;
          rcnt_nxt  = 24'd0;
        end
      endcase
    end
  end

  // a release on the same cycle as a repeat expiry wins and swallows the repeat
  always_comb begin
    press_nxt = 1'b0;
    rel_nxt   = fall;
    if (!fall) begin
      case (state)
        IDLE:    press_nxt = rise;
        DELAY:   press_nxt = REP_EN && (rcnt == RD_LAST);
        REPEAT:  press_nxt = REP_EN && (rcnt == RP_LAST);
        default: press_nxt = 1'b0;
      endcase
    end
  end

  assign level = stable;

endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES      = 400000,
  parameter int REPEAT_DELAY_CYCLES  = 16000000,
  parameter int REPEAT_PERIOD_CYCLES = 4000000,
  parameter int REPEAT_ENABLE        = 1,
  parameter int RAW_ACTIVE_LOW       = 0
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic BTN_LEFT_RAW,
  input  logic BTN_RIGHT_RAW,
  output logic BTN_LEFT,
  output logic BTN_RIGHT,
  output logic LEFT_PRESS,
  output logic RIGHT_PRESS,
  output logic LEFT_RELEASE,
  output logic RIGHT_RELEASE
);

  button_conditioner_chan #(
    .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
    .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
    .REPEAT_ENABLE        (REPEAT_ENABLE),
    .RAW_ACTIVE_LOW       (RAW_ACTIVE_LOW)
  ) u_left (
    .clk   (CLK),
    .rst_n (RESET_N),
    .raw   (BTN_LEFT_RAW),
    .level (BTN_LEFT),
    .press (LEFT_PRESS),
    .rel   (LEFT_RELEASE)
  );

  button_conditioner_chan #(
    .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
    .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
    .REPEAT_ENABLE        (REPEAT_ENABLE),
    .RAW_ACTIVE_LOW       (RAW_ACTIVE_LOW)
  ) u_right (
    .clk   (CLK),
    .rst_n (RESET_N),
    .raw   (BTN_RIGHT_RAW),
    .level (BTN_RIGHT),
    .press (RIGHT_PRESS),
    .rel   (RIGHT_RELEASE)
  );

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - bench for button_conditioner against a schedule-based reference model

module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic raw_l = 1'b0, raw_r = 1'b0, rawb_l = 1'b1, rawb_r = 1'b1;

  logic a_btn_l, a_btn_r, a_prs_l, a_prs_r, a_rel_l, a_rel_r;
  logic b_btn_l, b_btn_r, b_prs_l, b_prs_r, b_rel_l, b_rel_r;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY_CYCLES(RD), .REPEAT_PERIOD_CYCLES(RP),
    .REPEAT_ENABLE(1), .RAW_ACTIVE_LOW(0)
  ) dut_a (
    .CLK(CLK), .RESET_N(RESET_N), .BTN_LEFT_RAW(raw_l), .BTN_RIGHT_RAW(raw_r),
    .BTN_LEFT(a_btn_l), .BTN_RIGHT(a_btn_r), .LEFT_PRESS(a_prs_l), .RIGHT_PRESS(a_prs_r),
    .LEFT_RELEASE(a_rel_l), .RIGHT_RELEASE(a_rel_r)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY_CYCLES(RD), .REPEAT_PERIOD_CYCLES(RP),
    .REPEAT_ENABLE(0), .RAW_ACTIVE_LOW(1)
  ) dut_b (
    .CLK(CLK), .RESET_N(RESET_N), .BTN_LEFT_RAW(rawb_l), .BTN_RIGHT_RAW(rawb_r),
    .BTN_LEFT(b_btn_l), .BTN_RIGHT(b_btn_r), .LEFT_PRESS(b_prs_l), .RIGHT_PRESS(b_prs_r),
    .LEFT_RELEASE(b_rel_l), .RIGHT_RELEASE(b_rel_r)
  );

  // reference model: channels 0/1 are dut_a left/right, 2/3 are dut_b left/right
  bit   m_inv[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  bit   m_ren[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic m_s1[4], m_s2[4], m_stable[4], m_press[4], m_rel[4];
  int   m_run[4], m_t0[4];
  bit   m_held[4];
  int   edge_n = 0;
  int   cnt_press[4], cnt_rel[4];

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_stable[c] = 0; m_press[c] = 0; m_rel[c] = 0;
      m_run[c] = 0; m_t0[c] = 0; m_held[c] = 0;
    end
  endfunction

  // a new level is accepted once it has been seen D edges in a row; presses
  // follow the schedule t0, t0+RD, t0+RD+RP, ... while the button stays held
  function automatic void model_edge();
    logic r[4];
    r = '{raw_l, raw_r, rawb_l, rawb_r};
    edge_n++;
    for (int c = 0; c < 4; c++) begin
      bit rise = 0, fall = 0;
      int d;
      if (m_s2[c] != m_stable[c]) m_run[c]++; else m_run[c] = 0;
      if (m_run[c] == D) begin
        m_stable[c] = m_s2[c];
        m_run[c] = 0;
        rise = m_stable[c];
        fall = !m_stable[c];
      end
      m_s2[c] = m_s1[c];
      m_s1[c] = r[c] ^ m_inv[c];
      m_rel[c] = fall;
      m_press[c] = 0;
      if (fall) m_held[c] = 0;
      else if (rise) begin
        m_held[c] = 1; m_t0[c] = edge_n; m_press[c] = 1;
      end else if (m_held[c]) begin
        d = edge_n - m_t0[c];
        m_press[c] = m_ren[c] && d >= RD && ((d - RD) % RP == 0);
      end
    end
  endfunction

  function automatic logic [2:0] dut_obs(input int c);
    case (c)
      0: return {a_btn_l, a_prs_l, a_rel_l};
      1: return {a_btn_r, a_prs_r, a_rel_r};
      2: return {b_btn_l, b_prs_l, b_rel_l};
      default: return {b_btn_r, b_prs_r, b_rel_r};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    for (int c = 0; c < 4; c++) begin
      logic [2:0] e, o;
      e = {m_stable[c], m_press[c], m_rel[c]};
      o = dut_obs(c);
      n_tests++;
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s ch%0d edge%0d: observed lvl/prs/rel=%b expected %b", tag, c, edge_n, o, e);
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge CLK);
    if (!RESET_N) model_reset(); else model_edge();
    #1;
    check_model(tag);
    for (int c = 0; c < 4; c++) begin
      logic [2:0] o;
      o = dut_obs(c);
      cnt_press[c] += int'(o[1]);
      cnt_rel[c]   += int'(o[0]);
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 4; c++) begin cnt_press[c] = 0; cnt_rel[c] = 0; end
  endtask

  function automatic logic [11:0] all_outs();
    return {a_btn_l, a_btn_r, a_prs_l, a_prs_r, a_rel_l, a_rel_r,
            b_btn_l, b_btn_r, b_prs_l, b_prs_r, b_rel_l, b_rel_r};
  endfunction

  initial begin
    int hold[4];
    model_reset();
    for (int i = 0; i < 3; i++) step("reset");
    check("reset_outs", 32'(all_outs()), 32'h0);
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) step("idle");

    // clean press, held 30 cycles; the final repeat collides with the release
    clear_counts();
    raw_l = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step("clean_hold");
      if (i == 5) check("clean_btn_before", 32'(a_btn_l), 32'h0);
      if (i == 6) check("clean_btn_press", 32'({a_btn_l, a_prs_l}), 32'h3);
      if (i == 16) check("clean_first_repeat", 32'(a_prs_l), 32'h1);
    end
    raw_l = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step("clean_release");
      if (i == 6) check("coincide_release_no_press", 32'({a_prs_l, a_rel_l}), 32'h1);
    end
    check("clean_press_count", 32'(cnt_press[0]), 32'd5);
    check("clean_release_count", 32'(cnt_rel[0]), 32'd1);

    // bounce: 3-cycle runs are shorter than the debounce window
    clear_counts();
    for (int t = 0; t < 24; t++) begin
      raw_l = ((t / 3) % 2 == 0);
      step("bounce");
    end
    check("bounce_no_pulse", 32'(cnt_press[0] + cnt_rel[0]), 32'd0);
    raw_l = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step("bounce_settle");
      if (i == 6) check("bounce_press", 32'(a_prs_l), 32'h1);
    end
    raw_l = 1'b0;
    for (int i = 0; i < 12; i++) step("bounce_release");

    // both buttons on the same edge stay aligned through the repeat train
    raw_l = 1'b1; raw_r = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step("simul");
      check("simul_align", 32'(a_prs_l), 32'(a_prs_r));
    end
    raw_l = 1'b0; raw_r = 1'b0;
    for (int i = 0; i < 12; i++) step("simul_release");

    // held across reset, then reset again in the middle of the delay
    raw_l = 1'b1;
    RESET_N = 1'b0;
    model_reset();
    #1;
    check("reset_entry", 32'(all_outs()), 32'h0);
    for (int i = 0; i < 8; i++) step("held_in_reset");
    RESET_N = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step("held_after_reset");
      if (i == 6) check("held_press", 32'(a_prs_l), 32'h1);
    end
    RESET_N = 1'b0;
    model_reset();
    #1;
    check("reset_mid_delay", 32'(all_outs()), 32'h0);
    raw_l = 1'b0;
    for (int i = 0; i < 3; i++) step("reset_again");
    RESET_N = 1'b1;
    for (int i = 0; i < 10; i++) step("post_reset");

    // active-low raw with repeats disabled
    clear_counts();
    rawb_l = 1'b0;
    for (int i = 0; i < 40; i++) step("b_hold");
    check("b_press_count", 32'(cnt_press[2]), 32'd1);
    check("b_level", 32'(b_btn_l), 32'h1);
    rawb_l = 1'b1;
    for (int i = 0; i < 12; i++) step("b_release");
    check("b_release_count", 32'(cnt_rel[2]), 32'd1);
    check("b_press_total", 32'(cnt_press[2]), 32'd1);

    // random levels and hold times on all four inputs, with one reset mid-run
    for (int c = 0; c < 4; c++) hold[c] = 0;
    for (int n = 0; n < 1500; n++) begin
      logic v[4];
      v = '{raw_l, raw_r, rawb_l, rawb_r};
      for (int c = 0; c < 4; c++) begin
        if (hold[c] == 0) begin
          v[c] = 1'($urandom_range(0, 1));
          hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 8));
        end
        hold[c]--;
      end
      raw_l = v[0]; raw_r = v[1]; rawb_l = v[2]; rawb_r = v[3];
      if (n == 700) begin
        RESET_N = 1'b0;
        model_reset();
        #1;
        check("rand_reset_entry", 32'(all_outs()), 32'h0);
      end
      if (n == 703) RESET_N = 1'b1;
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
